core_id_stage_pipe: RTL and testbench

- Parametrised, pipelined successor to the core decode stage.
- Decodes one RV32I/RV32E instruction per cycle and reads an internal register file with write-back bypass.
- Detects load-use hazards and registers all decode results into an ID/EX pipeline register.
- Uses a valid/ready handshake upstream (IF) and downstream (EX), with flush support for taken branches and jumps.

---
 rtl/core_id_stage_pipe.sv | 273 +++++++++++++++++++++++++++
 tb/tb_core_id_stage_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_id_stage_pipe.sv
// RV32I/RV32E decode stage: register file with write-back bypass,
// load-use stall detection and a valid/ready ID/EX pipeline register.
module core_id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_id_ready,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_reg_write,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_rd_din,
    input  logic            i_ex_ready,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [6:0]      o_opcode,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [6:0]      o_funct7,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_rs1_dout,
    output logic [XLEN-1:0] o_rs2_dout,
    output logic            o_reg_write,
    output logic            o_mem_write,
    output logic            o_is_load,
    output logic            o_illegal,
    output logic [2:0]      o_mem_to_reg,
    output logic [1:0]      o_d_size,
    output logic            o_d_unsigned
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] M2R_ALU = 3'd0;
    localparam logic [2:0] M2R_MEM = 3'd1;
    localparam logic [2:0] M2R_PC4 = 3'd2;
    localparam logic [2:0] M2R_IMM = 3'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_dout;
        logic [XLEN-1:0] rs2_dout;
        logic            reg_write;
        logic            mem_write;
        logic            is_load;
        logic            illegal;
        logic [2:0]      mem_to_reg;
        logic [1:0]      d_size;
        logic            d_unsigned;
    } id_ex_t;

    logic [XLEN-1:0] rf_q [NREGS];
    logic            ex_valid_q;
    id_ex_t          idex_q;
    id_ex_t          idex_d;

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_opimm;
    logic is_op;
    logic legal;
    logic rd_used;
    logic rs1_used;
    logic rs2_used;
    logic bad_idx;
    logic illegal;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [2:0]      mem_to_reg;
    logic            wb_we;
    logic            hazard;
    logic            advance;

    // Index fits the implemented register file (RV32E has only 16)
    function automatic logic in_rng(input logic [4:0] a);
        return (NREGS == 32) || !a[4];
    endfunction

    // Register read: x0 and out-of-range indices return zero
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if ((a != 5'd0) && in_rng(a)) begin
            if (WB_BYPASS && i_wb_reg_write && (i_wb_rd == a)) begin
                v = i_rd_din;
            end else begin
                v = rf_q[a[AW-1:0]];
            end
        end
        return v;
    endfunction

    assign ins    = i_instr[31:0];
    assign opcode = ins[6:0];
    assign rd     = ins[11:7];
    assign funct3 = ins[14:12];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];
    assign funct7 = ins[31:25];

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_opimm  = (opcode == OP_OPIMM);
    assign is_op     = (opcode == OP_OP);

    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch
                 | is_load | is_store | is_opimm | is_op;

    assign rd_used  = is_lui | is_auipc | is_jal | is_jalr
                    | is_load | is_opimm | is_op;
    assign rs1_used = is_jalr | is_branch | is_load
                    | is_store | is_opimm | is_op;
    assign rs2_used = is_op | is_store | is_branch;

    assign bad_idx = (NREGS == 16)
                   && ((rd_used && rd[4])
                   ||  (rs1_used && rs1[4])
                   ||  (rs2_used && rs2[4]));

    assign illegal = ~legal | bad_idx;

    // Immediate assembly for the I/S/B/U/J formats
    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_jalr, is_load, is_opimm:
                imm32 = {{20{ins[31]}}, ins[31:20]};
            is_store:
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            is_branch:
                imm32 = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            is_lui, is_auipc:
                imm32 = {ins[31:12], 12'b0};
            is_jal:
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // Result select for the write-back mux
    always_comb begin
        mem_to_reg = M2R_ALU;
        unique case (1'b1)
            is_load:         mem_to_reg = M2R_MEM;
            is_jal, is_jalr: mem_to_reg = M2R_PC4;
            is_lui:          mem_to_reg = M2R_IMM;
            default:         mem_to_reg = M2R_ALU;
        endcase
    end

    // Next ID/EX contents from the instruction currently in ID
    always_comb begin
        idex_d            = '0;
        idex_d.pc         = i_pc;
        idex_d.opcode     = opcode;
        idex_d.rd         = rd;
        idex_d.funct3     = funct3;
        idex_d.rs1        = rs1;
        idex_d.rs2        = rs2;
        idex_d.funct7     = funct7;
        idex_d.imm        = imm;
        idex_d.rs1_dout   = rf_read(rs1);
        idex_d.rs2_dout   = rf_read(rs2);
        idex_d.reg_write  = rd_used & (rd != 5'd0) & ~illegal;
        idex_d.mem_write  = is_store & ~illegal;
        idex_d.is_load    = is_load;
        idex_d.illegal    = illegal;
        idex_d.mem_to_reg = mem_to_reg;
        idex_d.d_size     = funct3[1:0];
        idex_d.d_unsigned = funct3[2];
    end

    assign wb_we = i_wb_reg_write & (i_wb_rd != 5'd0) & in_rng(i_wb_rd);

    assign hazard = ex_valid_q & idex_q.is_load & (idex_q.rd != 5'd0)
                  & ((rs1_used & (rs1 == idex_q.rd))
                  |  (rs2_used & (rs2 == idex_q.rd)));

    assign advance    = ~ex_valid_q | i_ex_ready;
    assign o_id_ready = advance & ~hazard & i_rst_n;

    // Register file write port; x0 is never written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[i_wb_rd[AW-1:0]] <= i_rd_din;
        end
    end

    // ID/EX register: load on advance, bubble on hazard, kill on flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
        end else if (advance) begin
            ex_valid_q <= i_if_valid & ~hazard & ~i_flush;
            idex_q     <= idex_d;
        end else if (i_flush) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign o_ex_valid   = ex_valid_q;
    assign o_pc         = idex_q.pc;
    assign o_opcode     = idex_q.opcode;
    assign o_rd         = idex_q.rd;
    assign o_funct3     = idex_q.funct3;
    assign o_rs1        = idex_q.rs1;
    assign o_rs2        = idex_q.rs2;
    assign o_funct7     = idex_q.funct7;
    assign o_imm        = idex_q.imm;
    assign o_rs1_dout   = idex_q.rs1_dout;
    assign o_rs2_dout   = idex_q.rs2_dout;
    assign o_reg_write  = idex_q.reg_write;
    assign o_mem_write  = idex_q.mem_write;
    assign o_is_load    = idex_q.is_load;
    assign o_illegal    = idex_q.illegal;
    assign o_mem_to_reg = idex_q.mem_to_reg;
    assign o_d_size     = idex_q.d_size;
    assign o_d_unsigned = idex_q.d_unsigned;

endmodule

// File: tb/tb_core_id_stage_pipe.sv
// Scoreboard bench for core_id_stage_pipe: random + directed traffic,
// plus a small RV32E instance exercised directly.
module tb_core_id_stage_pipe;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_rst_n;
    logic        i_if_valid, i_flush, i_wb_reg_write, i_ex_ready;
    logic [31:0] i_instr, i_pc, i_rd_din;
    logic [4:0]  i_wb_rd;
    logic        o_id_ready, o_ex_valid;
    logic [31:0] o_pc, o_imm, o_rs1_dout, o_rs2_dout;
    logic [6:0]  o_opcode, o_funct7;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_funct3, o_mem_to_reg;
    logic [1:0]  o_d_size;
    logic        o_reg_write, o_mem_write, o_is_load, o_illegal, o_d_unsigned;

    logic        e_if_valid, e_wb_we;
    logic [31:0] e_instr, e_din;
    logic [4:0]  e_wb_rd;
    logic        e_id_ready, e_ex_valid;
    logic [31:0] e_pc, e_imm, e_rs1_dout, e_rs2_dout;
    logic [6:0]  e_opcode, e_funct7;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [2:0]  e_funct3, e_mem_to_reg;
    logic [1:0]  e_d_size;
    logic        e_reg_write, e_mem_write, e_is_load, e_illegal, e_d_unsigned;

    core_id_stage_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_valid(i_if_valid), .o_id_ready(o_id_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush),
        .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd),
        .i_rd_din(i_rd_din), .i_ex_ready(i_ex_ready),
        .o_ex_valid(o_ex_valid), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_rd(o_rd), .o_funct3(o_funct3), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_funct7(o_funct7), .o_imm(o_imm), .o_rs1_dout(o_rs1_dout),
        .o_rs2_dout(o_rs2_dout), .o_reg_write(o_reg_write),
        .o_mem_write(o_mem_write), .o_is_load(o_is_load),
        .o_illegal(o_illegal), .o_mem_to_reg(o_mem_to_reg),
        .o_d_size(o_d_size), .o_d_unsigned(o_d_unsigned)
    );

    core_id_stage_pipe #(.NREGS(16)) dut_e (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_valid(e_if_valid), .o_id_ready(e_id_ready),
        .i_instr(e_instr), .i_pc(32'h0), .i_flush(1'b0),
        .i_wb_reg_write(e_wb_we), .i_wb_rd(e_wb_rd),
        .i_rd_din(e_din), .i_ex_ready(1'b1),
        .o_ex_valid(e_ex_valid), .o_pc(e_pc), .o_opcode(e_opcode),
        .o_rd(e_rd), .o_funct3(e_funct3), .o_rs1(e_rs1), .o_rs2(e_rs2),
        .o_funct7(e_funct7), .o_imm(e_imm), .o_rs1_dout(e_rs1_dout),
        .o_rs2_dout(e_rs2_dout), .o_reg_write(e_reg_write),
        .o_mem_write(e_mem_write), .o_is_load(e_is_load),
        .o_illegal(e_illegal), .o_mem_to_reg(e_mem_to_reg),
        .o_d_size(e_d_size), .o_d_unsigned(e_d_unsigned)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc, ins, imm, a, b;
        logic [2:0]  m2r;
        logic        rw, mw, ld, ill, u1, u2;
    } exp_t;

    logic [31:0] mrf [32];
    exp_t        q [$];
    exp_t        slot;
    bit          slot_v;

    // Reference decode: classify opcode, build immediate arithmetically
    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [31:0] pc);
        exp_t e;
        int   cls;
        int   sx;
        sx = $signed(ins);
        case (ins[6:0])
            7'h37:   cls = 0;
            7'h17:   cls = 1;
            7'h6f:   cls = 2;
            7'h67:   cls = 3;
            7'h63:   cls = 4;
            7'h03:   cls = 5;
            7'h23:   cls = 6;
            7'h13:   cls = 7;
            7'h33:   cls = 8;
            default: cls = -1;
        endcase
        e.pc  = pc;
        e.ins = ins;
        e.a   = 0;
        e.b   = 0;
        case (cls)
            3, 5, 7: e.imm = 32'(sx >>> 20);
            6:       e.imm = 32'((sx >>> 25) * 32 + int'(ins[11:7]));
            4:       e.imm = 32'((sx >>> 31) * 4096 + int'(ins[7]) * 2048
                            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            0, 1:    e.imm = ins & 32'hffff_f000;
            2:       e.imm = 32'((sx >>> 31) * (1 << 20)
                            + int'(ins[19:12]) * 4096
                            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            default: e.imm = 0;
        endcase
        e.m2r = (cls == 5) ? 3'd1 :
                (cls == 2 || cls == 3) ? 3'd2 :
                (cls == 0) ? 3'd3 : 3'd0;
        e.rw  = (cls >= 0) && (cls != 4) && (cls != 6) && (ins[11:7] != 0);
        e.mw  = (cls == 6);
        e.ld  = (cls == 5);
        e.ill = (cls < 0);
        e.u1  = (cls >= 3);
        e.u2  = (cls == 4) || (cls == 6) || (cls == 8);
        return e;
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] r);
        if (r == 0) return 0;
        if (i_wb_reg_write && i_wb_rd == r) return i_rd_din;
        return mrf[r];
    endfunction

    // Model: predicts ready/valid each cycle and queues accepted work
    always @(negedge i_clk) begin
        exp_t e;
        bit adv, hz, rdy;
        if (!i_rst_n) begin
            chk("rst_ready", {31'b0, o_id_ready}, 0);
            chk("rst_valid", {31'b0, o_ex_valid}, 0);
            slot_v = 0;
            q.delete();
            for (int i = 0; i < 32; i++) mrf[i] = 0;
        end else begin
            chk("ex_valid", {31'b0, o_ex_valid}, {31'b0, slot_v});
            e = model(i_instr, i_pc);
            e.a = rdreg(i_instr[19:15]);
            e.b = rdreg(i_instr[24:20]);
            hz = slot_v && slot.ld && slot.ins[11:7] != 0
              && ((e.u1 && i_instr[19:15] == slot.ins[11:7])
              ||  (e.u2 && i_instr[24:20] == slot.ins[11:7]));
            adv = !slot_v || i_ex_ready;
            rdy = adv && !hz;
            chk("id_ready", {31'b0, o_id_ready}, {31'b0, rdy});
            if (adv) begin
                slot_v = i_if_valid && rdy && !i_flush;
                slot = e;
                if (slot_v) q.push_back(e);
            end else if (i_flush) begin
                slot_v = 0;
            end
            if (i_wb_reg_write && i_wb_rd != 0) mrf[i_wb_rd] = i_rd_din;
        end
    end

    // Monitor: compare ID/EX contents with the oldest queued entry
    always @(negedge i_clk) begin
        exp_t x;
        if (i_rst_n && o_ex_valid) begin
            if (q.size() == 0) begin
                chk("q_empty", 32'd1, 32'd0);
            end else begin
                x = q[0];
                chk("m_pc", o_pc, x.pc);
                chk("m_fields", {o_funct7, o_rs2, o_rs1, o_funct3, o_rd,
                                 o_opcode}, x.ins);
                chk("m_imm", o_imm, x.imm);
                chk("m_rs1v", o_rs1_dout, x.a);
                chk("m_rs2v", o_rs2_dout, x.b);
                chk("m_ctl", {20'b0, o_reg_write, o_mem_write, o_is_load,
                              o_illegal, 1'b0, o_mem_to_reg, o_d_size,
                              o_d_unsigned},
                    {20'b0, x.rw, x.mw, x.ld, x.ill, 1'b0, x.m2r,
                     x.ins[13:12], x.ins[14]});
                if (i_ex_ready || i_flush) void'(q.pop_front());
            end
        end
    end

    logic [31:0] pc_n = 32'h100;

    // One clock of stimulus; returns o_id_ready seen mid-cycle
    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic er, input logic fl, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       output logic rdy);
        i_if_valid     = v;
        i_instr        = ins;
        i_pc           = pc_n;
        i_ex_ready     = er;
        i_flush        = fl;
        i_wb_reg_write = we;
        i_wb_rd        = wrd;
        i_rd_din       = wd;
        pc_n           = pc_n + 4;
        @(negedge i_clk);
        rdy = o_id_ready;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] g;
        logic [6:0]  op;
        case ($urandom_range(0, 10))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6f;
            3: op = 7'h67;  4: op = 7'h63;  5: op = 7'h03;
            6: op = 7'h23;  7: op = 7'h13;  8: op = 7'h33;
            9: op = 7'h0f;  default: op = 7'h73;
        endcase
        g = $urandom;
        g[6:0]   = op;
        g[11:7]  = 5'($urandom_range(0, 7));
        g[19:15] = 5'($urandom_range(0, 7));
        g[24:20] = 5'($urandom_range(0, 7));
        return g;
    endfunction

    localparam logic [31:0] ADD6  = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] LW7   = {12'd8, 5'd1, 3'b010, 5'd7, 7'h03};
    localparam logic [31:0] ADD8  = {7'd0, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] SW3   = {7'h7f, 5'd3, 5'd1, 3'b010, 5'h1c, 7'h23};
    localparam logic [31:0] ADDI  = {12'd5, 5'd0, 3'd0, 5'd10, 7'h13};
    localparam logic [31:0] ADD9  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd9, 7'h33};

    initial begin
        logic r;
        i_rst_n = 0; i_if_valid = 0; i_instr = 0; i_pc = 0; i_flush = 0;
        i_wb_reg_write = 0; i_wb_rd = 0; i_rd_din = 0; i_ex_ready = 0;
        e_if_valid = 0; e_instr = 0; e_wb_we = 0; e_wb_rd = 0; e_din = 0;
        #1;
        chk("rst_hold_ready", {31'b0, o_id_ready}, 0);
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pc", o_pc, 0);
        chk("rst_imm", o_imm, 0);
        chk("rst_fld", {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}, 0);
        i_rst_n = 1;

        e_if_valid = 1;
        e_instr = {12'd1, 5'd0, 3'd0, 5'd17, 7'h13};
        e_wb_we = 1; e_wb_rd = 0; e_din = 32'hdead_beef;
        @(posedge i_clk); #1;
        chk("e_valid", {31'b0, e_ex_valid}, 1);
        chk("e_illegal_rd17", {31'b0, e_illegal}, 1);
        chk("e_rw_rd17", {31'b0, e_reg_write}, 0);
        e_instr = {7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'h33};
        @(posedge i_clk); #1;
        chk("e_x0_read", e_rs1_dout, 0);
        chk("e_legal", {31'b0, e_illegal}, 0);
        chk("e_rw", {31'b0, e_reg_write}, 1);
        e_instr = {7'd0, 5'd20, 5'd4, 3'd0, 5'd5, 7'h33};
        e_wb_rd = 4; e_din = 32'h0000_cafe;
        @(posedge i_clk); #1;
        chk("e_illegal_rs2", {31'b0, e_illegal}, 1);
        chk("e_byp", e_rs1_dout, 32'h0000_cafe);
        e_if_valid = 0; e_wb_we = 0;

        cyc(1, ADD6, 1, 0, 1, 5'd5, 32'h1234_5678, r);
        chk("byp_rs1", o_rs1_dout, 32'h1234_5678);
        chk("byp_rw", {31'b0, o_reg_write}, 1);
        chk("byp_m2r", {29'b0, o_mem_to_reg}, 0);

        cyc(1, LW7, 1, 0, 0, 5'd0, 0, r);
        chk("lw_acc", {31'b0, r}, 1);
        chk("lw_isload", {31'b0, o_is_load}, 1);
        cyc(1, ADD8, 1, 0, 0, 5'd0, 0, r);
        chk("lu_stall", {31'b0, r}, 0);
        chk("lu_bubble", {31'b0, o_ex_valid}, 0);
        cyc(1, ADD8, 1, 0, 0, 5'd0, 0, r);
        chk("lu_go", {31'b0, r}, 1);
        chk("lu_issue", {31'b0, o_ex_valid}, 1);
        chk("lu_rs1", {27'b0, o_rs1}, 7);

        cyc(1, SW3, 1, 0, 0, 5'd0, 0, r);
        for (int i = 0; i < 3; i++) begin
            cyc(1, ADD9, 0, 0, 0, 5'd0, 0, r);
            chk("bp_ready", {31'b0, r}, 0);
            chk("bp_valid", {31'b0, o_ex_valid}, 1);
            chk("bp_mw", {31'b0, o_mem_write}, 1);
            chk("bp_imm", o_imm, 32'hffff_fffc);
        end

        cyc(1, ADDI, 0, 1, 0, 5'd0, 0, r);
        chk("fl_kill", {31'b0, o_ex_valid}, 0);
        cyc(0, ADDI, 1, 0, 0, 5'd0, 0, r);
        chk("fl_noissue", {31'b0, o_ex_valid}, 0);
        cyc(1, ADDI, 1, 1, 0, 5'd0, 0, r);
        chk("fl_consumed", {31'b0, r}, 1);
        chk("fl_discard", {31'b0, o_ex_valid}, 0);

        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 9) < 8, gen(), $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                            : 5'($urandom_range(0, 7)),
                $urandom, r);
        end

        cyc(0, ADD9, 1, 0, 0, 5'd0, 0, r);
        cyc(0, ADD9, 1, 0, 0, 5'd0, 0, r);
        cyc(1, LW7, 1, 0, 0, 5'd0, 0, r);
        i_if_valid = 1; i_instr = ADD8; i_ex_ready = 1;
        i_flush = 0; i_wb_reg_write = 0;
        #1;
        chk("ar_stall", {31'b0, o_id_ready}, 0);
        chk("ar_pre_v", {31'b0, o_ex_valid}, 1);
        #1;
        i_rst_n = 0;
        #1;
        chk("ar_valid", {31'b0, o_ex_valid}, 0);
        chk("ar_ready", {31'b0, o_id_ready}, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1;
        i_if_valid = 0;
        #1;
        chk("ar_pc", o_pc, 0);
        chk("ar_ctl", {25'b0, o_reg_write, o_mem_write, o_is_load,
                       o_illegal, o_mem_to_reg}, 0);
        cyc(1, ADD6, 1, 0, 0, 5'd0, 0, r);
        chk("ar_rf_clear", o_rs1_dout, 0);
        chk("ar_issue", {31'b0, o_ex_valid}, 1);
        cyc(0, ADD9, 1, 0, 0, 5'd0, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
